// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one Avalon-style memory bus between the
// instruction-fetch port and the load/store port, one transaction at a time.
module mem_bus_arbiter #(
    parameter logic FIRST_GRANT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_req,
    input  logic [31:0] instr_address,
    output logic        instr_ack,
    output logic [31:0] instr_readdata,
    input  logic        data_req,
    input  logic        data_write,
    input  logic [3:0]  data_byteenable,
    input  logic [31:0] data_address,
    input  logic [31:0] data_writedata,
    output logic        data_ack,
    output logic [31:0] data_readdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] mem_address,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    typedef struct packed {
        logic        write;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_req_t;

    state_t   state;
    logic     owner;       // 0 = instruction port, 1 = data port
    logic     last_grant;
    logic     grant;
    bus_req_t instr_bus, data_bus, win_bus;

    always_comb begin
        instr_bus = '{write: 1'b0, be: 4'hF, addr: instr_address, wdata: 32'h0};
        data_bus  = '{write: data_write, be: data_byteenable,
                      addr: data_address, wdata: data_writedata};
        // On a conflict the port that did not win last time goes first.
        if (instr_req && data_req) grant = ~last_grant;
        else                       grant = data_req;
        win_bus = grant ? data_bus : instr_bus;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            owner          <= 1'b0;
            last_grant     <= ~FIRST_GRANT;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_byteenable <= 4'h0;
            mem_address    <= 32'h0;
            mem_writedata  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_req || data_req) begin
                        state          <= ISSUE;
                        owner          <= grant;
                        last_grant     <= grant;
                        mem_read       <= ~win_bus.write;
                        mem_write      <= win_bus.write;
                        mem_byteenable <= win_bus.be;
                        mem_address    <= win_bus.addr;
                        mem_writedata  <= win_bus.wdata;
                    end
                end
                ISSUE: begin
                    if (!mem_waitrequest) begin
                        state     <= RESP;
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Read data arrives the cycle after acceptance, i.e. while in RESP.
    assign busy           = (state != IDLE);
    assign instr_ack      = (state == RESP) && !owner;
    assign data_ack       = (state == RESP) && owner;
    assign instr_readdata = instr_ack ? mem_readdata : 32'h0;
    assign data_readdata  = data_ack  ? mem_readdata : 32'h0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomised checks of mem_bus_arbiter against a small slave
// memory and a reference memory model.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_req;
    logic [31:0] instr_address;
    logic        instr_ack;
    logic [31:0] instr_readdata;
    logic        data_req;
    logic        data_write;
    logic [3:0]  data_byteenable;
    logic [31:0] data_address;
    logic [31:0] data_writedata;
    logic        data_ack;
    logic [31:0] data_readdata;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    mem_bus_arbiter #(.FIRST_GRANT(1'b0)) dut (
        .clk(clk), .reset(reset),
        .instr_req(instr_req), .instr_address(instr_address),
        .instr_ack(instr_ack), .instr_readdata(instr_readdata),
        .data_req(data_req), .data_write(data_write),
        .data_byteenable(data_byteenable), .data_address(data_address),
        .data_writedata(data_writedata), .data_ack(data_ack),
        .data_readdata(data_readdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_waitrequest(mem_waitrequest), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // Slave: 64-word memory indexed by address[7:2], programmable wait states.
    logic [31:0] smem [64] = '{default: '0};
    logic [31:0] rdq = '0;
    bit          loaded = 1'b0;
    bit          rand_mode = 1'b0;
    int          wait_n = 0;
    int          cur_wait = 0;
    int          cnt = 0;

    assign mem_waitrequest = (mem_read || mem_write) && (cnt < cur_wait);
    assign mem_readdata    = rdq;

    always @(posedge clk) begin
        if (!loaded) begin
            smem[0] <= 32'h3C011234;
            smem[4] <= 32'h11223344;
            loaded  <= 1'b1;
        end
        if (reset || !(mem_read || mem_write)) begin
            cnt      <= 0;
            cur_wait <= rand_mode ? int'($urandom_range(0, 3)) : wait_n;
        end else if (mem_waitrequest) begin
            cnt <= cnt + 1;
        end else begin
            if (mem_read)  rdq <= smem[mem_address[7:2]];
            if (mem_write) smem[mem_address[7:2]] <=
                merge(smem[mem_address[7:2]], mem_writedata, mem_byteenable);
        end
    end

    logic [31:0] ref_mem [64] = '{default: '0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        vectors++; if (mem_read !== 1'b0) begin miscompares++; $display("FAIL reset_mem_read: got %h expected 0", mem_read); end
        vectors++; if (mem_write !== 1'b0) begin miscompares++; $display("FAIL reset_mem_write: got %h expected 0", mem_write); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %h expected 0", busy); end
        vectors++; if ({instr_ack, data_ack} !== 2'b00) begin miscompares++; $display("FAIL reset_acks: got %b expected 00", {instr_ack, data_ack}); end
        vectors++; if (mem_address !== 32'h0) begin miscompares++; $display("FAIL reset_mem_address: got %h expected 0", mem_address); end
        vectors++; if ({mem_byteenable, mem_writedata} !== 36'h0) begin miscompares++; $display("FAIL reset_be_wdata: got %h expected 0", {mem_byteenable, mem_writedata}); end
    endtask

    task automatic test_single_fetch();
        instr_address = 32'hBFC00000;
        instr_req = 1'b1;
        vectors++; if (mem_read !== 1'b0) begin miscompares++; $display("FAIL fetch_no_comb_strobe: got %h expected 0", mem_read); end
        step();
        vectors++; if (mem_read !== 1'b1) begin miscompares++; $display("FAIL fetch_mem_read: got %h expected 1", mem_read); end
        vectors++; if (mem_address !== 32'hBFC00000) begin miscompares++; $display("FAIL fetch_address: got %h expected bfc00000", mem_address); end
        vectors++; if (mem_byteenable !== 4'hF) begin miscompares++; $display("FAIL fetch_be: got %h expected f", mem_byteenable); end
        vectors++; if (instr_ack !== 1'b0) begin miscompares++; $display("FAIL fetch_early_ack: got %h expected 0", instr_ack); end
        step();
        vectors++; if (instr_ack !== 1'b1) begin miscompares++; $display("FAIL fetch_ack: got %h expected 1", instr_ack); end
        vectors++; if (instr_readdata !== 32'h3C011234) begin miscompares++; $display("FAIL fetch_data: got %h expected 3c011234", instr_readdata); end
        vectors++; if (data_ack !== 1'b0) begin miscompares++; $display("FAIL fetch_data_ack: got %h expected 0", data_ack); end
        vectors++; if (mem_read !== 1'b0) begin miscompares++; $display("FAIL fetch_strobe_drop: got %h expected 0", mem_read); end
        instr_req = 1'b0;
        step();
        vectors++; if ({instr_ack, busy} !== 2'b00) begin miscompares++; $display("FAIL fetch_idle: got %b expected 00", {instr_ack, busy}); end
        vectors++; if (instr_readdata !== 32'h0) begin miscompares++; $display("FAIL fetch_data_gated: got %h expected 0", instr_readdata); end
    endtask

    task automatic test_store_load();
        data_write = 1'b1;
        data_byteenable = 4'b0011;
        data_address = 32'hBFC00010;
        data_writedata = 32'hAABBCCDD;
        data_req = 1'b1;
        step();
        vectors++; if ({mem_write, mem_read} !== 2'b10) begin miscompares++; $display("FAIL store_strobes: got %b expected 10", {mem_write, mem_read}); end
        vectors++; if (mem_byteenable !== 4'b0011) begin miscompares++; $display("FAIL store_be: got %h expected 3", mem_byteenable); end
        vectors++; if (mem_writedata !== 32'hAABBCCDD) begin miscompares++; $display("FAIL store_wdata: got %h expected aabbccdd", mem_writedata); end
        step();
        vectors++; if ({data_ack, instr_ack} !== 2'b10) begin miscompares++; $display("FAIL store_ack: got %b expected 10", {data_ack, instr_ack}); end
        data_req = 1'b0;
        step();
        data_write = 1'b0;
        data_req = 1'b1;
        step();
        vectors++; if ({mem_write, mem_read} !== 2'b01) begin miscompares++; $display("FAIL load_strobes: got %b expected 01", {mem_write, mem_read}); end
        step();
        vectors++; if (data_ack !== 1'b1) begin miscompares++; $display("FAIL load_ack: got %h expected 1", data_ack); end
        vectors++; if (data_readdata !== 32'h1122CCDD) begin miscompares++; $display("FAIL load_merged: got %h expected 1122ccdd", data_readdata); end
        data_req = 1'b0;
        step();
    endtask

    task automatic test_conflict();
        logic exp_i, exp_d;
        reset = 1'b1;
        instr_address = 32'hBFC00000;
        instr_req = 1'b1;
        data_write = 1'b0;
        data_address = 32'hBFC00010;
        data_req = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            step();
            exp_i = (c == 2) || (c == 8);
            exp_d = (c == 5) || (c == 11);
            vectors++; if ({instr_ack, data_ack} !== {exp_i, exp_d}) begin miscompares++; $display("FAIL conflict_acks_c%0d: got %b expected %b", c, {instr_ack, data_ack}, {exp_i, exp_d}); end
            if (exp_i) begin
                vectors++; if (instr_readdata !== 32'h3C011234) begin miscompares++; $display("FAIL conflict_idata_c%0d: got %h expected 3c011234", c, instr_readdata); end
            end
            if (exp_d) begin
                vectors++; if (data_readdata !== 32'h1122CCDD) begin miscompares++; $display("FAIL conflict_ddata_c%0d: got %h expected 1122ccdd", c, data_readdata); end
            end
        end
        instr_req = 1'b0;
        data_req = 1'b0;
        step();
    endtask

    task automatic test_wait_states();
        wait_n = 3;
        step();
        instr_address = 32'hBFC00000;
        instr_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step();
            vectors++; if ({mem_read, instr_ack} !== 2'b10) begin miscompares++; $display("FAIL wait_strobe_c%0d: got %b expected 10", c, {mem_read, instr_ack}); end
            vectors++; if (mem_address !== 32'hBFC00000) begin miscompares++; $display("FAIL wait_addr_c%0d: got %h expected bfc00000", c, mem_address); end
        end
        step();
        vectors++; if (instr_ack !== 1'b1) begin miscompares++; $display("FAIL wait_ack: got %h expected 1", instr_ack); end
        vectors++; if (instr_readdata !== 32'h3C011234) begin miscompares++; $display("FAIL wait_data: got %h expected 3c011234", instr_readdata); end
        instr_req = 1'b0;
        wait_n = 0;
        step();
    endtask

    task automatic test_reset_mid_issue();
        wait_n = 10;
        step();
        data_write = 1'b1;
        data_byteenable = 4'hF;
        data_address = 32'hBFC00020;
        data_writedata = 32'h55667788;
        data_req = 1'b1;
        step();
        vectors++; if (mem_write !== 1'b1) begin miscompares++; $display("FAIL rst_store_strobe: got %h expected 1", mem_write); end
        step();
        reset = 1'b1;
        data_req = 1'b0;
        step();
        vectors++; if ({mem_write, busy, data_ack} !== 3'b000) begin miscompares++; $display("FAIL rst_mid_issue: got %b expected 000", {mem_write, busy, data_ack}); end
        reset = 1'b0;
        wait_n = 0;
        step();
        vectors++; if ({data_ack, busy} !== 2'b00) begin miscompares++; $display("FAIL rst_no_late_ack: got %b expected 00", {data_ack, busy}); end
        data_write = 1'b0;
        data_req = 1'b1;
        step();
        vectors++; if (mem_read !== 1'b1) begin miscompares++; $display("FAIL rst_fresh_read: got %h expected 1", mem_read); end
        step();
        vectors++; if (data_ack !== 1'b1) begin miscompares++; $display("FAIL rst_fresh_ack: got %h expected 1", data_ack); end
        vectors++; if (data_readdata !== 32'h0) begin miscompares++; $display("FAIL rst_store_dropped: got %h expected 0", data_readdata); end
        data_req = 1'b0;
        step();
    endtask

    task automatic test_soak();
        bit i_out = 1'b0;
        bit d_out = 1'b0;
        int issued = 0;
        int done = 0;
        int cyc = 0;
        logic [31:0] exp;
        rand_mode = 1'b1;
        instr_req = 1'b0;
        data_req = 1'b0;
        while (cyc < 20000) begin
            vectors++; if (mem_read && mem_write) begin miscompares++; $display("FAIL soak_both_strobes: got 11 expected not 11"); end
            vectors++; if (instr_ack && data_ack) begin miscompares++; $display("FAIL soak_both_acks: got 11 expected not 11"); end
            if (instr_ack) begin
                exp = ref_mem[instr_address[7:2]];
                vectors++;
                if (!i_out) begin miscompares++; $display("FAIL soak_spurious_iack: got 1 expected 0"); end
                else if (instr_readdata !== exp) begin miscompares++; $display("FAIL soak_idata: got %h expected %h", instr_readdata, exp); end
                i_out = 1'b0;
                done++;
            end
            if (data_ack) begin
                exp = ref_mem[data_address[7:2]];
                vectors++;
                if (!d_out) begin miscompares++; $display("FAIL soak_spurious_dack: got 1 expected 0"); end
                else if (!data_write && data_readdata !== exp) begin miscompares++; $display("FAIL soak_ddata: got %h expected %h", data_readdata, exp); end
                if (d_out && data_write)
                    ref_mem[data_address[7:2]] = merge(exp, data_writedata, data_byteenable);
                d_out = 1'b0;
                done++;
            end
            if (!i_out) begin
                if (issued < 1000 && $urandom_range(0, 1) == 1) begin
                    instr_address = 32'h1040 + 32'($urandom_range(0, 7)) * 4;
                    instr_req = 1'b1;
                    i_out = 1'b1;
                    issued++;
                end else instr_req = 1'b0;
            end
            if (!d_out) begin
                if (issued < 1000 && $urandom_range(0, 1) == 1) begin
                    data_address = 32'h1040 + 32'($urandom_range(0, 7)) * 4;
                    data_write = 1'($urandom_range(0, 1));
                    data_byteenable = 4'($urandom_range(0, 15));
                    data_writedata = $urandom;
                    data_req = 1'b1;
                    d_out = 1'b1;
                    issued++;
                end else data_req = 1'b0;
            end
            if (done == 1000 && !i_out && !d_out) break;
            step();
            cyc++;
        end
        vectors++; if (done != 1000 || i_out || d_out) begin miscompares++; $display("FAIL soak_completion: got %0d acks expected 1000", done); end
        rand_mode = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        instr_req = 1'b0;
        instr_address = 32'h0;
        data_req = 1'b0;
        data_write = 1'b0;
        data_byteenable = 4'h0;
        data_address = 32'h0;
        data_writedata = 32'h0;
        test_reset();
        test_single_fetch();
        test_store_load();
        test_conflict();
        test_wait_states();
        test_reset_mid_issue();
        test_soak();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter that shares the CPU's single Avalon-style memory bus between the instruction-fetch port and the data (load/store) port. It sits between the CPU core and the memory: it latches one request at a time, drives it onto the bus until the slave drops `waitrequest`, then returns a one-cycle acknowledge with read data to the port that issued it. Conflicts are resolved round-robin. Memory read data is valid the cycle after the transaction is accepted.

## Interface
- `FIRST_GRANT`, default 0: port that wins the first conflict after reset (0 = instruction, 1 = data).
- `clk` input 1: clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `instr_req` input 1: instruction read request, held as a level.
- `instr_address` input 32 (`size_t`): fetch address.
- `instr_ack` output 1: one-cycle pulse when the fetch completes.
- `instr_readdata` output 32: fetched word; `mem_readdata` while `instr_ack`=1, otherwise 0.
- `data_req` input 1: data request, held as a level.
- `data_write` input 1: 1 = store, 0 = load. Sampled together with `data_req`.
- `data_byteenable` input 4: byte lanes for a store.
- `data_address` input 32: load/store address.
- `data_writedata` input 32: store data.
- `data_ack` output 1: one-cycle completion pulse.
- `data_readdata` output 32: load result; `mem_readdata` while `data_ack`=1, otherwise 0.
- `mem_read` output 1, `mem_write` output 1: bus strobes, never both 1.
- `mem_byteenable` output 4, `mem_address` output 32, `mem_writedata` output 32: registered bus fields.
- `mem_readdata` input 32, `mem_waitrequest` input 1: slave response.
- `busy` output 1: 1 in ISSUE or RESP.

## Operation
- States: IDLE, ISSUE, RESP.
- **IDLE:**
  - If no request is pending, stay in IDLE.
  - Otherwise pick a winner:
    - Only one requester: grant it.
    - Both requesting: grant the port that is not `last_grant`.
  - On the edge that leaves IDLE, latch the winner's fields and set `owner` and `last_grant` to the winner. Next state is ISSUE.
  - An instruction grant latches `mem_byteenable`=4'hF, write=0, and writedata=0.
- **ISSUE:**
  - Drive `mem_read`/`mem_write` from the latched write flag, with the latched address, byteenable and writedata.
  - Stay in ISSUE while `mem_waitrequest`=1 at the edge.
  - At the first edge with `mem_waitrequest`=0, the slave accepts the transaction. Go to RESP and deassert both strobes on that edge.
- **RESP:**
  - Assert the owner's ack for exactly one cycle.
  - Gate `mem_readdata` onto the owner's readdata port. Acks also occur for stores; store readdata is don't-care but still gated.
  - Next state is IDLE.
- **Requester rule:**
  - A port holds req and all of its fields stable until it sees ack.
  - In the cycle after ack, req must be low or already carry the next request. IDLE re-samples req in that cycle.
  - Field changes while the port's request is latched are ignored.
- **Reset:**
  - State returns to IDLE; `mem_read`, `mem_write`, both acks and `busy` become 0.
  - `mem_address`, `mem_writedata` and `mem_byteenable` become 0.
  - `last_grant` becomes the complement of `FIRST_GRANT`.
  - A latched or in-flight transaction is discarded with no ack, including reset asserted during ISSUE or RESP.

## Timing
- Minimum latency: req high in cycle N (IDLE), strobe in N+1, ack and data in N+2.
- Each extra waitrequest cycle adds one cycle.
- Throughput: one transaction per 3 cycles with no wait states.
- Strobes and bus fields are registered: no combinational path from req to `mem_*`.
- `*_ack` and `*_readdata` are combinational from state and `mem_readdata`.
- Req rising during ISSUE or RESP is only considered at the next IDLE.
- Both ports requesting continuously produce a strict alternation of grants.

## Test plan
- **Single fetch:**
  - Reset, then `instr_req`=1, `instr_address`=0xBFC00000, memory word 0x3C011234, no wait states.
  - `mem_read`=1 one cycle later; `instr_ack`=1 with `instr_readdata`=0x3C011234 two cycles after req.
  - `data_ack` stays 0.
- **Store then load:**
  - `data_write`=1, `data_byteenable`=4'b0011, address 0xBFC00010, writedata 0xAABBCCDD over an old word 0x11223344.
  - `mem_write`=1 with byteenable 4'b0011.
  - A following load of the same address returns `data_readdata`=0x1122CCDD.
- **Conflict:**
  - Both req high from reset with `FIRST_GRANT`=0.
  - Grants are instr, data, instr, data.
  - Acks land on cycles 2, 5, 8, 11 after req, never both in the same cycle.
- **Wait states:**
  - Slave holds `mem_waitrequest`=1 for 3 edges.
  - `mem_read` and `mem_address` stay stable for those cycles.
  - Ack arrives exactly 3 cycles later than in the no-wait case; no ack during the wait.
- **Reset mid-ISSUE:**
  - Assert reset while a store is waiting.
  - Next cycle `mem_write`=0, `busy`=0, no `data_ack`.
  - After release, a fresh request completes normally.
- **Randomised waitrequest soak:**
  - 1000 mixed transactions from both ports with random waitrequest.
  - Every req gets exactly one ack; `mem_read` and `mem_write` are never both 1.
  - Load data matches a reference memory model.
